// File: rtl/instruction_dispatcher.sv
// In-order instruction dispatcher: a small FIFO in front of a matmul engine,
// holding dependent (MMUL_D) ops until all earlier ops have completed.
package instruction_dispatcher_pkg;
  typedef enum logic {MMUL_D = 1'b0, MMUL_ND = 1'b1} op_t;
  typedef logic [7:0] addr_t;
  typedef struct packed {
    op_t   op;
    addr_t dest;
    addr_t src1;
    addr_t src2;
  } instruction_t;
endpackage

module instruction_dispatcher
  import instruction_dispatcher_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  instruction_t                 in_inst,
  input  logic                         in_valid,
  output logic                         in_ready,
  output instruction_t                 exec_inst,
  output logic                         exec_valid,
  input  logic                         exec_ready,
  input  logic                         exec_done,
  output logic [$clog2(MAX_OUT+1)-1:0] outstanding,
  output logic                         idle,
  output logic                         err_done
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OUT_W = $clog2(MAX_OUT + 1);
  localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUT);
  localparam logic [OUT_W-1:0] OUT_ONE = OUT_W'(1);
  localparam logic [PTR_W:0]   PTR_ONE = (PTR_W + 1)'(1);

  instruction_t     mem [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic [OUT_W-1:0] out_cnt;
  logic             accept_en;
  logic             err_q;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  // A completion with nothing in flight is an error and must not underflow.
  function automatic logic [OUT_W-1:0] next_count(input logic [OUT_W-1:0] cnt,
                                                  input logic             inc,
                                                  input logic             dec);
    logic [OUT_W-1:0] n;
    n = cnt;
    if (inc) n = n + OUT_ONE;
    if (dec && (cnt != '0)) n = n - OUT_ONE;
    return n;
  endfunction

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

  assign in_ready   = accept_en && !full;
  assign exec_inst  = mem[rd_ptr[PTR_W-1:0]];
  assign exec_valid = !empty && (out_cnt < OUT_MAX) &&
                      ((exec_inst.op == MMUL_ND) || (out_cnt == '0));

  assign push = in_valid && in_ready;
  assign pop  = exec_valid && exec_ready;

  assign outstanding = out_cnt;
  assign idle        = empty && (out_cnt == '0);
  assign err_done    = err_q;

  // Control state: pointers, in-flight count, error flag, post-reset accept enable
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      out_cnt   <= '0;
      err_q     <= 1'b0;
      accept_en <= 1'b0;
    end else begin
      accept_en <= 1'b1;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      out_cnt <= next_count(out_cnt, pop, exec_done);
      if (exec_done && (out_cnt == '0)) err_q <= 1'b1;
    end
  end

  // Storage: data only, never reset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PTR_W-1:0]] <= in_inst;
  end

endmodule

// File: tb/tb_instruction_dispatcher.sv
// Bench for instruction_dispatcher: cycle table, directed corner sequences and
// random traffic checked against a queue-based reference model.
module tb_instruction_dispatcher;
  import instruction_dispatcher_pkg::*;

  localparam int DEPTH   = 4;
  localparam int MAX_OUT = 2;
  localparam int OUT_W   = $clog2(MAX_OUT + 1);

  logic             clk;
  logic             reset;
  instruction_t     in_inst;
  logic             in_valid;
  logic             in_ready;
  instruction_t     exec_inst;
  logic             exec_valid;
  logic             exec_ready;
  logic             exec_done;
  logic [OUT_W-1:0] outstanding;
  logic             idle;
  logic             err_done;

  instruction_dispatcher #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_inst    (in_inst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .exec_inst  (exec_inst),
    .exec_valid (exec_valid),
    .exec_ready (exec_ready),
    .exec_done  (exec_done),
    .outstanding(outstanding),
    .idle       (idle),
    .err_done   (err_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: FIFO contents as a queue, in-flight count as an integer
  instruction_t mq[$];
  int           mouts;
  bit           merr;
  bit           macc;

  typedef struct {
    logic         iv;
    instruction_t ii;
    logic         er;
    logic         ed;
    logic         x_rdy;
    logic         x_vld;
    int           x_out;
    logic         x_idle;
    logic         x_err;
    instruction_t x_inst;
  } vec_t;

  vec_t vt[18];

  function automatic instruction_t mki(op_t op, logic [7:0] d, logic [7:0] s1, logic [7:0] s2);
    instruction_t t;
    t.op = op; t.dest = d; t.src1 = s1; t.src2 = s2;
    return t;
  endfunction

  function automatic vec_t mkv(logic iv, instruction_t ii, logic er, logic ed, logic r,
                               logic v, int o, logic id, logic e, instruction_t xi);
    vec_t x;
    x.iv = iv; x.ii = ii; x.er = er; x.ed = ed;
    x.x_rdy = r; x.x_vld = v; x.x_out = o; x.x_idle = id; x.x_err = e; x.x_inst = xi;
    return x;
  endfunction

  function automatic bit m_ready();
    return macc && (mq.size() < DEPTH);
  endfunction

  function automatic bit m_valid();
    if (mq.size() == 0) return 1'b0;
    if (mouts >= MAX_OUT) return 1'b0;
    return (mq[0].op == MMUL_ND) || (mouts == 0);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    chk("in_ready", 64'(in_ready), 64'(m_ready()));
    chk("exec_valid", 64'(exec_valid), 64'(m_valid()));
    if (m_valid()) chk("exec_inst", 64'(exec_inst), 64'(mq[0]));
    chk("outstanding", 64'(outstanding), 64'(mouts));
    chk("idle", 64'(idle), 64'((mq.size() == 0) && (mouts == 0)));
    chk("err_done", 64'(err_done), 64'(merr));
  endtask

  task automatic model_step(input logic iv, input instruction_t ii, input logic er, input logic ed);
    bit rdy, vld;
    int old;
    rdy = m_ready();
    vld = m_valid();
    old = mouts;
    if (vld && er) begin
      void'(mq.pop_front());
      mouts++;
    end
    if (ed) begin
      if (old == 0) merr = 1'b1;
      else mouts--;
    end
    if (iv && rdy) mq.push_back(ii);
    macc = 1'b1;
  endtask

  // Called #1 after a rising edge: check, drive, advance one clock
  task automatic tick(input logic iv, input instruction_t ii, input logic er, input logic ed);
    in_valid = iv; in_inst = ii; exec_ready = er; exec_done = ed;
    model_check();
    model_step(iv, ii, er, ed);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; in_valid = 1'b0; exec_ready = 1'b0; exec_done = 1'b1;
    #1;
    chk("rst_idle", 64'(idle), 64'(1));
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_exec_valid", 64'(exec_valid), 64'(0));
    chk("rst_outstanding", 64'(outstanding), 64'(0));
    chk("rst_err", 64'(err_done), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_out", 64'(outstanding), 64'(0));
    chk("rst_hold_err", 64'(err_done), 64'(0));
    chk("rst_hold_rdy", 64'(in_ready), 64'(0));
    exec_done = 1'b0;
    mq.delete(); mouts = 0; merr = 1'b0; macc = 1'b0;
    reset = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    instruction_t z, a1, b0, b1, b2, c0, c1, h;
    instruction_t f[5];
    instruction_t issued[5];
    instruction_t r_ii;
    logic r_iv, r_er, r_ed;
    int pushed, got;

    z  = '0;
    a1 = mki(MMUL_ND, 8'h10, 8'h01, 8'h02);
    b0 = mki(MMUL_ND, 8'h20, 8'h21, 8'h22);
    b1 = mki(MMUL_ND, 8'h30, 8'h31, 8'h32);
    b2 = mki(MMUL_ND, 8'h40, 8'h41, 8'h42);
    c0 = mki(MMUL_ND, 8'h50, 8'h51, 8'h52);
    c1 = mki(MMUL_D,  8'h60, 8'h61, 8'h62);
    h  = mki(MMUL_ND, 8'hA5, 8'h5A, 8'hC3);

    //            iv  ii  er ed   rdy vld out idle err inst
    vt[0]  = mkv(0, z,  1, 0,  1,  0,  0,  1,  0,  z);
    vt[1]  = mkv(1, a1, 1, 0,  1,  1,  0,  0,  0,  a1);
    vt[2]  = mkv(0, z,  1, 0,  1,  0,  1,  0,  0,  z);
    vt[3]  = mkv(0, z,  1, 1,  1,  0,  0,  1,  0,  z);
    vt[4]  = mkv(1, b0, 1, 0,  1,  1,  0,  0,  0,  b0);
    vt[5]  = mkv(1, b1, 1, 0,  1,  1,  1,  0,  0,  b1);
    vt[6]  = mkv(1, b2, 1, 0,  1,  0,  2,  0,  0,  z);
    vt[7]  = mkv(0, z,  1, 0,  1,  0,  2,  0,  0,  z);
    vt[8]  = mkv(0, z,  1, 1,  1,  1,  1,  0,  0,  b2);
    vt[9]  = mkv(0, z,  1, 0,  1,  0,  2,  0,  0,  z);
    vt[10] = mkv(0, z,  0, 1,  1,  0,  1,  0,  0,  z);
    vt[11] = mkv(0, z,  0, 1,  1,  0,  0,  1,  0,  z);
    vt[12] = mkv(1, c0, 1, 0,  1,  1,  0,  0,  0,  c0);
    vt[13] = mkv(1, c1, 1, 0,  1,  0,  1,  0,  0,  z);
    vt[14] = mkv(0, z,  1, 0,  1,  0,  1,  0,  0,  z);
    vt[15] = mkv(0, z,  1, 1,  1,  1,  0,  0,  0,  c1);
    vt[16] = mkv(0, z,  1, 0,  1,  0,  1,  0,  0,  z);
    vt[17] = mkv(0, z,  1, 1,  1,  0,  0,  1,  0,  z);

    in_inst = '0; in_valid = 1'b0; exec_ready = 1'b0; exec_done = 1'b0;
    mouts = 0; merr = 1'b0; macc = 1'b0;
    do_reset();

    // Single issue, MAX_OUT limit, dependent hold
    for (int i = 0; i < 18; i++) begin
      tick(vt[i].iv, vt[i].ii, vt[i].er, vt[i].ed);
      chk($sformatf("row%0d_in_ready", i), 64'(in_ready), 64'(vt[i].x_rdy));
      chk($sformatf("row%0d_exec_valid", i), 64'(exec_valid), 64'(vt[i].x_vld));
      chk($sformatf("row%0d_outstanding", i), 64'(outstanding), 64'(vt[i].x_out));
      chk($sformatf("row%0d_idle", i), 64'(idle), 64'(vt[i].x_idle));
      chk($sformatf("row%0d_err", i), 64'(err_done), 64'(vt[i].x_err));
      if (vt[i].x_vld) chk($sformatf("row%0d_inst", i), 64'(exec_inst), 64'(vt[i].x_inst));
    end

    // Spurious completion while idle: sticky error, count stays 0
    tick(1'b0, z, 1'b0, 1'b1);
    chk("err_set", 64'(err_done), 64'(1));
    chk("err_out_zero", 64'(outstanding), 64'(0));
    repeat (3) tick(1'b0, z, 1'b0, 1'b0);
    chk("err_sticky", 64'(err_done), 64'(1));
    do_reset();
    tick(1'b0, z, 1'b0, 1'b0);

    // Fill to full with engine stalled, then drain through a pointer wrap
    for (int i = 0; i < 5; i++)
      f[i] = mki((i == 2) ? MMUL_D : MMUL_ND, 8'(8'h70 + i), 8'(8'h80 + i), 8'(8'h90 + i));
    for (int i = 0; i < 4; i++) tick(1'b1, f[i], 1'b0, 1'b0);
    chk("full_in_ready", 64'(in_ready), 64'(0));
    chk("full_exec_valid", 64'(exec_valid), 64'(1));
    chk("full_head", 64'(exec_inst), 64'(f[0]));
    pushed = 4;
    got = 0;
    for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
      r_iv = (pushed < 5);
      r_ii = r_iv ? f[pushed] : z;
      r_ed = (mouts > 0);
      if (exec_valid) begin
        issued[got] = exec_inst;
        got++;
      end
      if (r_iv && in_ready) pushed++;
      tick(r_iv, r_ii, 1'b1, r_ed);
    end
    chk("drain_count", 64'(got), 64'(5));
    for (int i = 0; i < 5; i++)
      if (i < got) chk($sformatf("drain_order%0d", i), 64'(issued[i]), 64'(f[i]));
    for (int cyc = 0; cyc < 10 && mouts > 0; cyc++) tick(1'b0, z, 1'b0, 1'b1);
    chk("drain_idle", 64'(idle), 64'(1));

    // Reset with 3 queued and 2 in flight, then restart cleanly
    tick(1'b1, mki(MMUL_ND, 8'h01, 8'h02, 8'h03), 1'b1, 1'b0);
    tick(1'b1, mki(MMUL_ND, 8'h04, 8'h05, 8'h06), 1'b1, 1'b0);
    tick(1'b1, mki(MMUL_ND, 8'h07, 8'h08, 8'h09), 1'b1, 1'b0);
    tick(1'b1, mki(MMUL_D,  8'h0A, 8'h0B, 8'h0C), 1'b1, 1'b0);
    tick(1'b1, mki(MMUL_ND, 8'h0D, 8'h0E, 8'h0F), 1'b1, 1'b0);
    chk("pre_rst_out", 64'(outstanding), 64'(2));
    chk("pre_rst_idle", 64'(idle), 64'(0));
    do_reset();
    tick(1'b0, z, 1'b0, 1'b0);
    tick(1'b1, h, 1'b1, 1'b0);
    chk("post_rst_valid", 64'(exec_valid), 64'(1));
    chk("post_rst_inst", 64'(exec_inst), 64'(h));
    tick(1'b0, z, 1'b1, 1'b0);
    chk("post_rst_out", 64'(outstanding), 64'(1));
    tick(1'b0, z, 1'b0, 1'b1);
    chk("post_rst_idle", 64'(idle), 64'(1));

    // Random traffic against the model; completions only when something is in flight
    for (int cyc = 0; cyc < 400; cyc++) begin
      r_iv = 1'($urandom_range(0, 1));
      r_ii = mki(op_t'(1'($urandom_range(0, 1))), 8'($urandom), 8'($urandom), 8'($urandom));
      r_er = ($urandom_range(0, 3) != 0);
      r_ed = (mouts > 0) && ($urandom_range(0, 2) == 0);
      tick(r_iv, r_ii, r_er, r_ed);
    end
    model_check();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
